// File: rtl/bus_decoder_pkg.sv
// Shared register-bus definitions: widths, default decoder sizing and the
// sequencer state encoding used by the decoder and the read mux.
package bus_decoder_pkg;

    localparam int REG_WIDTH       = 32;
    localparam int BUS_ADDR_WIDTH  = $clog2(REG_WIDTH);
    localparam int DEF_NUM_SLAVES  = 2;
    localparam int DEF_TIMEOUT     = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_e;

endpackage

// File: rtl/bus_timer.sv
// Clearable up-counter with a terminal-count flag; used to bound how long
// the decoder waits in ACCESS for a slave ack.
module bus_timer #(
    parameter int W  = 4,
    parameter int TC = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc_o = (cnt_q == W'(TC));

endmodule

// File: rtl/bus_decoder.sv
// Register-bus initiator: decodes the slave index, drives one-hot select and
// latched address/data, waits for the selected ack or a timeout, responds.
module bus_decoder
    import bus_decoder_pkg::*;
#(
    parameter int DATA_WIDTH = REG_WIDTH,
    parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
    parameter int NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m_req,
    input  logic                  m_we,
    input  logic [ADDR_WIDTH-1:0] m_addr,
    input  logic [DATA_WIDTH-1:0] m_wdata,
    output logic                  m_ack,
    output logic                  m_err,
    output logic [NUM_SLAVES-1:0] s_sel,
    output logic                  s_we,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [NUM_SLAVES-1:0] s_ack,
    output logic [ADDR_WIDTH-1:0] rd_sel,
    output bus_state_e            dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    bus_state_e            state_q, state_d;
    logic                  m_ack_q, m_ack_d;
    logic                  m_err_q, m_err_d;
    logic [NUM_SLAVES-1:0] s_sel_q, s_sel_d;
    logic                  s_we_q, s_we_d;
    logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
    logic [DATA_WIDTH-1:0] s_wdata_q, s_wdata_d;
    logic [ADDR_WIDTH-1:0] rd_sel_q, rd_sel_d;

    logic tmr_clr, tmr_en, tmr_tc;
    logic addr_ok, ack_hit;

    bus_timer #(
        .W  (CNT_W),
        .TC (TIMEOUT - 1)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .tc_o  (tmr_tc)
    );

    assign addr_ok = (m_addr < ADDR_WIDTH'(NUM_SLAVES));
    // s_sel_q is one-hot on the latched index, so masking filters out acks
    // from slaves that were not addressed.
    assign ack_hit = |(s_ack & s_sel_q);

    always_comb begin
        state_d   = state_q;
        m_ack_d   = 1'b0;
        m_err_d   = 1'b0;
        s_sel_d   = s_sel_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        rd_sel_d  = rd_sel_q;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (m_req) begin
                    s_addr_d  = m_addr;
                    s_we_d    = m_we;
                    s_wdata_d = m_wdata;
                    rd_sel_d  = m_addr;
                    if (addr_ok) begin
                        s_sel_d = NUM_SLAVES'(1) << m_addr;
                        state_d = ST_ACCESS;
                    end else begin
                        s_sel_d = '0;
                        m_ack_d = 1'b1;
                        m_err_d = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                tmr_en = 1'b1;
                if (ack_hit || tmr_tc) begin
                    s_sel_d = '0;
                    s_we_d  = 1'b0;
                    m_ack_d = 1'b1;
                    m_err_d = !ack_hit;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                tmr_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                tmr_clr   = 1'b1;
                s_sel_d   = '0;
                s_we_d    = 1'b0;
                s_addr_d  = '0;
                s_wdata_d = '0;
                rd_sel_d  = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            m_ack_q   <= 1'b0;
            m_err_q   <= 1'b0;
            s_sel_q   <= '0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            rd_sel_q  <= '0;
        end else begin
            state_q   <= state_d;
            m_ack_q   <= m_ack_d;
            m_err_q   <= m_err_d;
            s_sel_q   <= s_sel_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            rd_sel_q  <= rd_sel_d;
        end
    end

    assign m_ack     = m_ack_q;
    assign m_err     = m_err_q;
    assign s_sel     = s_sel_q;
    assign s_we      = s_we_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign rd_sel    = rd_sel_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder: write, read, bad address, timeout,
// ack-vs-timeout priority, dropped requests and reset mid-access.
module tb_bus_decoder;
    import bus_decoder_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 2;
    localparam int TO = 15;

    logic          clk;
    logic          rst_n;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_ack;
    logic          m_err;
    logic [NS-1:0] s_sel;
    logic          s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [NS-1:0] s_ack;
    logic [AW-1:0] rd_sel;
    bus_state_e    dbg_state;

    int n_tests;
    int n_fail;
    int ack_cnt;

    bus_decoder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_SLAVES (NS),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_ack     (m_ack),
        .m_err     (m_err),
        .s_sel     (s_sel),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_ack     (s_ack),
        .rd_sel    (rd_sel),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1ns after the next rising edge: inputs are driven and
    // registered outputs sampled here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".m_ack"},   64'(m_ack),   64'd0);
        check({tag, ".m_err"},   64'(m_err),   64'd0);
        check({tag, ".s_sel"},   64'(s_sel),   64'd0);
        check({tag, ".s_we"},    64'(s_we),    64'd0);
        check({tag, ".s_addr"},  64'(s_addr),  64'd0);
        check({tag, ".s_wdata"}, 64'(s_wdata), 64'd0);
        check({tag, ".rd_sel"},  64'(rd_sel),  64'd0);
        check({tag, ".state"},   64'(dbg_state), 64'd0);
    endtask

    // Drive a request for exactly one cycle (cycle 0); returns at cycle 1.
    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        m_req   = 1'b1;
        m_we    = we;
        m_addr  = addr;
        m_wdata = wd;
        next_cycle();
        m_req   = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        s_ack   = '0;
        repeat (3) next_cycle();
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Write to slave 1, ack arrives in cycle 2
        issue(1'b1, 5'd1, 32'hDEADBEEF);
        check("wr.c1.s_sel",   64'(s_sel),   64'b10);
        check("wr.c1.s_we",    64'(s_we),    64'd1);
        check("wr.c1.s_wdata", 64'(s_wdata), 64'hDEADBEEF);
        check("wr.c1.s_addr",  64'(s_addr),  64'd1);
        check("wr.c1.rd_sel",  64'(rd_sel),  64'd1);
        check("wr.c1.m_ack",   64'(m_ack),   64'd0);
        check("wr.c1.state",   64'(dbg_state), 64'd1);
        next_cycle();
        s_ack = 2'b10;
        check("wr.c2.s_sel", 64'(s_sel), 64'b10);
        check("wr.c2.m_ack", 64'(m_ack), 64'd0);
        next_cycle();
        s_ack = 2'b00;
        check("wr.c3.m_ack",  64'(m_ack),  64'd1);
        check("wr.c3.m_err",  64'(m_err),  64'd0);
        check("wr.c3.s_sel",  64'(s_sel),  64'd0);
        check("wr.c3.s_we",   64'(s_we),   64'd0);
        check("wr.c3.rd_sel", 64'(rd_sel), 64'd1);
        check("wr.c3.state",  64'(dbg_state), 64'd2);
        next_cycle();
        check("wr.c4.m_ack", 64'(m_ack), 64'd0);
        check("wr.c4.state", 64'(dbg_state), 64'd0);
        check("wr.c4.rd_sel", 64'(rd_sel), 64'd1);

        // Read from slave 0 with immediate ack
        issue(1'b0, 5'd0, 32'h12345678);
        s_ack = 2'b01;
        check("rd.c1.s_sel",  64'(s_sel),  64'b01);
        check("rd.c1.s_we",   64'(s_we),   64'd0);
        check("rd.c1.rd_sel", 64'(rd_sel), 64'd0);
        next_cycle();
        s_ack = 2'b00;
        check("rd.c2.m_ack", 64'(m_ack), 64'd1);
        check("rd.c2.m_err", 64'(m_err), 64'd0);
        check("rd.c2.s_sel", 64'(s_sel), 64'd0);
        next_cycle();
        check("rd.c3.m_ack", 64'(m_ack), 64'd0);

        // Bad address: immediate error response, no select
        issue(1'b0, 5'd5, 32'h0);
        check("bad.c1.m_ack",  64'(m_ack),  64'd1);
        check("bad.c1.m_err",  64'(m_err),  64'd1);
        check("bad.c1.s_sel",  64'(s_sel),  64'd0);
        check("bad.c1.rd_sel", 64'(rd_sel), 64'd5);
        check("bad.c1.s_addr", 64'(s_addr), 64'd5);
        next_cycle();
        check("bad.c2.m_ack", 64'(m_ack), 64'd0);
        check("bad.c2.s_sel", 64'(s_sel), 64'd0);
        check("bad.c2.state", 64'(dbg_state), 64'd0);

        // Timeout on slave 0 with only wrong-slave acks, plus requests
        // raised in ACCESS (cycle 5) and RESP (cycle 16) that must be dropped
        ack_cnt = 0;
        issue(1'b0, 5'd0, 32'h0);
        for (int c = 1; c <= 20; c++) begin
            s_ack = (c <= 3) ? 2'b10 : 2'b00;
            m_req = (c == 5 || c == 16);
            m_addr = (c == 5 || c == 16) ? 5'd1 : 5'd0;
            if (m_ack) ack_cnt++;
            check($sformatf("to.c%0d.m_ack", c), 64'(m_ack), 64'(c == 16));
            check($sformatf("to.c%0d.m_err", c), 64'(m_err), 64'(c == 16));
            check($sformatf("to.c%0d.s_sel", c), 64'(s_sel), (c <= 15) ? 64'b01 : 64'b00);
            next_cycle();
        end
        m_req  = 1'b0;
        m_addr = '0;
        s_ack  = '0;
        check("to.ack_count", 64'(ack_cnt), 64'd1);
        check("to.rd_sel", 64'(rd_sel), 64'd0);

        // Valid ack in the same cycle the timeout would fire: ack wins
        issue(1'b0, 5'd1, 32'h0);
        for (int c = 1; c <= 16; c++) begin
            s_ack = (c == 15) ? 2'b10 : 2'b00;
            check($sformatf("pri.c%0d.m_ack", c), 64'(m_ack), 64'(c == 16));
            check($sformatf("pri.c%0d.m_err", c), 64'(m_err), 64'd0);
            next_cycle();
        end
        s_ack = '0;
        check("pri.idle", 64'(dbg_state), 64'd0);

        // Reset asserted mid-cycle during ACCESS at cycle 3
        issue(1'b1, 5'd1, 32'hCAFEF00D);
        next_cycle();
        next_cycle();
        check("rst.pre.s_sel", 64'(s_sel), 64'b10);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst.async");
        s_ack = 2'b10;
        next_cycle();
        s_ack = 2'b00;
        check("rst.hold.m_ack", 64'(m_ack), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            check($sformatf("rst.post%0d.m_ack", c), 64'(m_ack), 64'd0);
            check($sformatf("rst.post%0d.s_sel", c), 64'(s_sel), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
